ps2_keyboard: RTL
=================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000; the idle-gap limit, in clk cycles, between PS/2 clock falling edges inside one frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2; the synchronizer depth for ps2_clk and ps2_data.
REQ-003 SHALL have input clk, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have input ps2_clk, 1 bit: asynchronous PS/2 device clock.
REQ-006 SHALL have input ps2_data, 1 bit: asynchronous PS/2 device data.
REQ-007 SHALL have output keyboard, 10 bits: last decoded key event as {ext, brk, code[7:0]}, held until the next event.
REQ-008 SHALL have output code_valid, 1 bit: one-cycle pulse when keyboard is updated.
REQ-009 SHALL have output frame_err, 1 bit: one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flip-flops each before any use.
REQ-011 SHALL detect a PS/2 falling edge as synchronized ps2_clk at 1 in the previous cycle and 0 in the current cycle; ps2_data SHALL be sampled in that same cycle.
REQ-012 SHALL use FSM states IDLE, RECV and DONE.
REQ-013 SHALL treat a frame as 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-014 In IDLE, a falling edge with data=0 SHALL enter RECV with bit count 1; a falling edge with data=1 SHALL be ignored with no error.
REQ-015 In RECV, each falling edge SHALL store one bit and increment the 4-bit bit counter; the 11th bit SHALL move the FSM to DONE.
REQ-016 In DONE (one cycle), the FSM SHALL check XOR(data[7:0], parity)==1 and stop==1, then return to IDLE.
REQ-017 A good byte of 8'hE0 SHALL set the ext flag; code_valid SHALL not pulse.
REQ-018 A good byte of 8'hF0 SHALL set the brk flag; code_valid SHALL not pulse.
REQ-019 Any other good byte SHALL load keyboard={ext,brk,byte} and pulse code_valid in the DONE cycle, registered and visible the cycle after; ext and brk SHALL then be cleared.
REQ-020 Latency: keyboard and code_valid SHALL change exactly 2 clk cycles after the cycle in which the 11th falling edge is detected.
REQ-021 A bad byte (parity error or stop=0) SHALL pulse frame_err, discard the byte, clear ext and brk, and leave keyboard unchanged.
REQ-022 In RECV, a 16-bit gap counter SHALL reset on each falling edge; when it reaches TIMEOUT_CYCLES, the FSM SHALL pulse frame_err, go to IDLE, and clear the bit count, ext and brk.
REQ-023 Repeated identical codes (typematic repeat) SHALL each pulse code_valid.
REQ-024 code_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 reset SHALL set the FSM to IDLE and clear keyboard, the bit count, the gap counter, ext, brk, code_valid, frame_err and all synchronizer flops to 1 (bus idle).
REQ-026 reset asserted mid-frame SHALL abandon the frame with no code_valid or frame_err pulse.
REQ-027 When reset and a falling edge coincide, reset SHALL win.

Structure
REQ-028 Package ps2_pkg SHALL hold PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, FRAME_BITS=11 and the FSM state enum.
REQ-029 Sub-module ps2_sync_edge SHALL contain the synchronizers and the falling-edge detector, with outputs fall_pulse and data_s.

Verification
REQ-030 Frame 0x1C, parity 0 -> keyboard=10'h01C, one code_valid pulse 2 cycles after the 11th edge.
REQ-031 Frames F0 then 1D -> keyboard=10'h11D with a single code_valid pulse; no pulse for the F0 frame.
REQ-032 Frames E0, F0, 75 -> keyboard=10'h375; ext and brk are 0 afterwards (a following 0x23 gives 10'h023).
REQ-033 Frame 0x23 with parity 1 -> frame_err pulse; keyboard holds its prior value 10'h01C; no code_valid pulse.
REQ-034 Stop after 5 bits for TIMEOUT_CYCLES cycles -> frame_err pulse; a subsequent clean 0x1C frame decodes to 10'h01C.
REQ-035 reset asserted after 6 bits of the 0x23 frame -> keyboard=10'h000 with no pulses; a following full 0x1D frame gives 10'h01D.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and frame-check helper for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam int         FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_e;

  // Frame layout after LSB-first shifting: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && f[FRAME_BITS-1] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the PS/2 clock and data lines and flags falling edges of the PS/2 clock.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_pulse,
  output logic data_s
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;

  // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q[0]  <= ps2_clk_i;
      data_sync_q[0] <= ps2_data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync_q[i]  <= clk_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_pulse = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign data_s     = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: frames 11-bit words, validates them and folds E0/F0 prefixes into key events.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] keyboard,
  output logic       code_valid,
  output logic       frame_err
);

  logic fall_pulse;
  logic data_s;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .fall_pulse(fall_pulse),
    .data_s    (data_s)
  );

  state_e                  state_q;
  logic [3:0]              bit_cnt_q;
  logic [15:0]             gap_q;
  logic [FRAME_BITS-1:0]   frame_q;
  logic [FRAME_BITS-1:0]   frame_d;
  logic                    ext_q;
  logic                    brk_q;
  logic [9:0]              keyboard_q;
  logic                    code_valid_q;
  logic                    frame_err_q;
  logic [7:0]              byte_w;

  assign frame_d = {data_s, frame_q[FRAME_BITS-1:1]};
  assign byte_w  = frame_q[8:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      gap_q        <= '0;
      frame_q      <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keyboard_q   <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_pulse && !data_s) begin
            frame_q   <= frame_d;
            bit_cnt_q <= 4'd1;
            gap_q     <= '0;
            state_q   <= RECV;
          end
        end
        RECV: begin
          if (fall_pulse) begin
            frame_q   <= frame_d;
            gap_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(FRAME_BITS - 1)) state_q <= DONE;
          end else if (gap_q == 16'(TIMEOUT_CYCLES)) begin
            // Device stalled mid-frame: drop everything, including pending prefixes.
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            gap_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
          if (!frame_ok(frame_q)) begin
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
          end else if (byte_w == PREFIX_EXT) begin
            ext_q <= 1'b1;
          end else if (byte_w == PREFIX_BRK) begin
            brk_q <= 1'b1;
          end else begin
            keyboard_q   <= {ext_q, brk_q, byte_w};
            code_valid_q <= 1'b1;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign keyboard   = keyboard_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule
